// File: rtl/bpd_bob.sv
// Branch order buffer: snapshots predicted branches at fetch and turns in-order resolves into predictor updates.
// Optional retire/mispredict statistics counters are built when BPD_BOB_STATS_EN is defined.
module bpd_bob #(
  parameter int DEPTH    = 16,
  parameter int LOGDEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic                alloc_valid_i,
  input  logic [63:0]         alloc_pc_i,
  input  logic [11:0]         alloc_bhr_i,
  input  logic [9:0]          alloc_lochist_i,
  input  logic                alloc_pred_i,
  input  logic                alloc_lpred_i,
  input  logic                alloc_ch_we_i,
  output logic                alloc_ready_o,
  input  logic                retire_valid_i,
  input  logic                retire_brdir_i,
  output logic [63:0]         bob_pc_r_o,
  output logic [11:0]         bob_bhr_r_o,
  output logic [9:0]          bob_lochist_r_o,
  output logic                bob_valid_r_o,
  output logic                bpd_rt_ud_o,
  output logic                bpd_rt_brdir_o,
  output logic                bpd_ch_we_o,
  output logic                bpd_ch_dir_o,
  output logic                bob_mispredict_o,
  output logic [LOGDEPTH:0]   bob_count_o,
  output logic                bob_underflow_o,
  output logic [31:0]         stat_retired_o,
  output logic [31:0]         stat_mispred_o
);

  typedef struct packed {
    logic [63:0] pc;
    logic [11:0] bhr;
    logic [9:0]  lochist;
    logic        pred;
    logic        lpred;
    logic        ch_we;
  } entry_t;

  localparam logic [LOGDEPTH:0] PTR_ONE   = (LOGDEPTH+1)'(1);
  localparam logic [LOGDEPTH:0] DEPTH_CNT = (LOGDEPTH+1)'(DEPTH);

  entry_t mem [DEPTH];

  logic [LOGDEPTH:0]   head, tail;
  logic [LOGDEPTH:0]   head_next, tail_next;
  logic [LOGDEPTH:0]   count_next;
  logic [LOGDEPTH-1:0] head_idx, tail_idx;
  entry_t              head_entry;
  entry_t              alloc_entry;
  logic                empty;
  logic                pop;
  logic                mispred;
  logic                drop;
  logic                push;
  logic                ready_q;
  logic                underflow_q;

  // Handshake: an entry is taken on a clock edge where alloc_valid_i and
  // alloc_ready_o are both high and no flush or mispredicting retire drops it;
  // fetch must hold alloc_valid_i and its payload until that edge.
  assign head_idx    = head[LOGDEPTH-1:0];
  assign tail_idx    = tail[LOGDEPTH-1:0];
  assign head_entry  = mem[head_idx];
  assign empty       = (head == tail);
  assign pop         = retire_valid_i & ~empty;
  assign mispred     = pop & (retire_brdir_i ^ head_entry.pred);
  assign drop        = flush_i | mispred;
  assign push        = alloc_valid_i & ready_q & ~drop;

  assign alloc_entry = '{pc:      alloc_pc_i,
                         bhr:     alloc_bhr_i,
                         lochist: alloc_lochist_i,
                         pred:    alloc_pred_i,
                         lpred:   alloc_lpred_i,
                         ch_we:   alloc_ch_we_i};

  // A mispredict pops the head and throws away every younger wrong-path entry.
  always_comb begin
    head_next = head;
    tail_next = tail;
    if (mispred) begin
      head_next = head + PTR_ONE;
      tail_next = head + PTR_ONE;
    end else begin
      if (pop)     head_next = head + PTR_ONE;
      if (push)    tail_next = tail + PTR_ONE;
      if (flush_i) head_next = tail_next;
    end
    count_next = tail_next - head_next;
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      head        <= '0;
      tail        <= '0;
      ready_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      head    <= head_next;
      tail    <= tail_next;
      ready_q <= (count_next != DEPTH_CNT);
      if (retire_valid_i && empty) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail_idx] <= alloc_entry;
  end

  // Strobes pulse for one cycle after a pop; snapshot fields hold until the next pop.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      bob_pc_r_o       <= '0;
      bob_bhr_r_o      <= '0;
      bob_lochist_r_o  <= '0;
      bob_valid_r_o    <= 1'b0;
      bpd_rt_ud_o      <= 1'b0;
      bpd_rt_brdir_o   <= 1'b0;
      bpd_ch_we_o      <= 1'b0;
      bpd_ch_dir_o     <= 1'b0;
      bob_mispredict_o <= 1'b0;
    end else begin
      bob_valid_r_o    <= pop;
      bpd_rt_ud_o      <= pop;
      bpd_rt_brdir_o   <= pop & retire_brdir_i;
      bpd_ch_we_o      <= pop & head_entry.ch_we;
      bpd_ch_dir_o     <= pop & (retire_brdir_i ^ head_entry.lpred);
      bob_mispredict_o <= mispred;
      if (pop) begin
        bob_pc_r_o      <= head_entry.pc;
        bob_bhr_r_o     <= head_entry.bhr;
        bob_lochist_r_o <= head_entry.lochist;
      end
    end
  end

  assign alloc_ready_o   = ready_q;
  assign bob_count_o     = tail - head;
  assign bob_underflow_o = underflow_q;

`ifdef BPD_BOB_STATS_EN
  logic [31:0] stat_retired_q;
  logic [31:0] stat_mispred_q;

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      stat_retired_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (pop && (stat_retired_q != 32'hFFFF_FFFF))
        stat_retired_q <= stat_retired_q + 32'd1;
      if (mispred && (stat_mispred_q != 32'hFFFF_FFFF))
        stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_retired_o = stat_retired_q;
  assign stat_mispred_o = stat_mispred_q;
`else
  assign stat_retired_o = 32'h0;
  assign stat_mispred_o = 32'h0;
`endif

endmodule

// File: tb/tb_bpd_bob.sv
// Directed bench for bpd_bob: a queue-based reference model checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_bpd_bob;
  localparam int DEPTH    = 16;
  localparam int LOGDEPTH = 4;

  logic                clock;
  logic                reset_n;
  logic                flush_i;
  logic                alloc_valid_i;
  logic [63:0]         alloc_pc_i;
  logic [11:0]         alloc_bhr_i;
  logic [9:0]          alloc_lochist_i;
  logic                alloc_pred_i;
  logic                alloc_lpred_i;
  logic                alloc_ch_we_i;
  logic                alloc_ready_o;
  logic                retire_valid_i;
  logic                retire_brdir_i;
  logic [63:0]         bob_pc_r_o;
  logic [11:0]         bob_bhr_r_o;
  logic [9:0]          bob_lochist_r_o;
  logic                bob_valid_r_o;
  logic                bpd_rt_ud_o;
  logic                bpd_rt_brdir_o;
  logic                bpd_ch_we_o;
  logic                bpd_ch_dir_o;
  logic                bob_mispredict_o;
  logic [LOGDEPTH:0]   bob_count_o;
  logic                bob_underflow_o;
  logic [31:0]         stat_retired_o;
  logic [31:0]         stat_mispred_o;

  int total = 0;
  int bad   = 0;

  bpd_bob #(.DEPTH(DEPTH), .LOGDEPTH(LOGDEPTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .flush_i          (flush_i),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_pc_i       (alloc_pc_i),
    .alloc_bhr_i      (alloc_bhr_i),
    .alloc_lochist_i  (alloc_lochist_i),
    .alloc_pred_i     (alloc_pred_i),
    .alloc_lpred_i    (alloc_lpred_i),
    .alloc_ch_we_i    (alloc_ch_we_i),
    .alloc_ready_o    (alloc_ready_o),
    .retire_valid_i   (retire_valid_i),
    .retire_brdir_i   (retire_brdir_i),
    .bob_pc_r_o       (bob_pc_r_o),
    .bob_bhr_r_o      (bob_bhr_r_o),
    .bob_lochist_r_o  (bob_lochist_r_o),
    .bob_valid_r_o    (bob_valid_r_o),
    .bpd_rt_ud_o      (bpd_rt_ud_o),
    .bpd_rt_brdir_o   (bpd_rt_brdir_o),
    .bpd_ch_we_o      (bpd_ch_we_o),
    .bpd_ch_dir_o     (bpd_ch_dir_o),
    .bob_mispredict_o (bob_mispredict_o),
    .bob_count_o      (bob_count_o),
    .bob_underflow_o  (bob_underflow_o),
    .stat_retired_o   (stat_retired_o),
    .stat_mispred_o   (stat_mispred_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO of in-flight branches
  typedef struct {
    logic [63:0] pc;
    logic [11:0] bhr;
    logic [9:0]  loch;
    logic        pred;
    logic        lpred;
    logic        chwe;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  logic        m_mis_now = 1'b0;
  logic        m_ready   = 1'b1;
  logic        m_valid   = 1'b0;
  logic        m_brdir   = 1'b0;
  logic        m_chwe    = 1'b0;
  logic        m_chdir   = 1'b0;
  logic        m_misp    = 1'b0;
  logic        m_under   = 1'b0;
  logic [63:0] m_pc      = '0;
  logic [11:0] m_bhr     = '0;
  logic [9:0]  m_loch    = '0;
  logic [31:0] m_ret     = '0;
  logic [31:0] m_mis     = '0;

  always @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      mq.delete();
      m_ready = 1'b1; m_valid = 1'b0; m_brdir = 1'b0; m_chwe = 1'b0;
      m_chdir = 1'b0; m_misp = 1'b0; m_under = 1'b0;
      m_pc = '0; m_bhr = '0; m_loch = '0; m_ret = '0; m_mis = '0;
    end else begin
      m_mis_now = 1'b0;
      m_valid = 1'b0; m_brdir = 1'b0; m_chwe = 1'b0; m_chdir = 1'b0; m_misp = 1'b0;
      if (retire_valid_i) begin
        if (mq.size() == 0) begin
          m_under = 1'b1;
        end else begin
          m_e     = mq.pop_front();
          m_valid = 1'b1;
          m_brdir = retire_brdir_i;
          m_pc    = m_e.pc;
          m_bhr   = m_e.bhr;
          m_loch  = m_e.loch;
          m_chwe  = m_e.chwe;
          m_chdir = (retire_brdir_i != m_e.lpred);
          m_mis_now = (retire_brdir_i != m_e.pred);
          m_misp  = m_mis_now;
          if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
          if (m_mis_now) begin
            mq.delete();
            if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
          end
        end
      end
      if (alloc_valid_i && m_ready && !flush_i && !m_mis_now)
        mq.push_back('{alloc_pc_i, alloc_bhr_i, alloc_lochist_i,
                       alloc_pred_i, alloc_lpred_i, alloc_ch_we_i});
      if (flush_i) mq.delete();
      m_ready = (mq.size() != DEPTH);
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("m_valid",  bob_valid_r_o,    m_valid);
      chk("m_ud",     bpd_rt_ud_o,      m_valid);
      chk("m_brdir",  bpd_rt_brdir_o,   m_brdir);
      chk("m_chwe",   bpd_ch_we_o,      m_chwe);
      chk("m_chdir",  bpd_ch_dir_o,     m_chdir);
      chk("m_misp",   bob_mispredict_o, m_misp);
      chk("m_pc",     bob_pc_r_o,       m_pc);
      chk("m_bhr",    bob_bhr_r_o,      m_bhr);
      chk("m_loch",   bob_lochist_r_o,  m_loch);
      chk("m_count",  bob_count_o,      64'(mq.size()));
      chk("m_ready",  alloc_ready_o,    m_ready);
      chk("m_under",  bob_underflow_o,  m_under);
`ifdef BPD_BOB_STATS_EN
      chk("m_sret",   stat_retired_o,   m_ret);
      chk("m_smis",   stat_mispred_o,   m_mis);
`else
      chk("m_sret",   stat_retired_o,   64'h0);
      chk("m_smis",   stat_mispred_o,   64'h0);
`endif
    end
  end

  // driver tasks: inputs change #1 after the rising edge
  task automatic drive(input logic av, input logic [63:0] pc, input logic [11:0] bhr,
                       input logic [9:0] loch, input logic pred, input logic lpred,
                       input logic chwe, input logic rv, input logic brdir, input logic fl);
    alloc_valid_i   = av;
    alloc_pc_i      = pc;
    alloc_bhr_i     = bhr;
    alloc_lochist_i = loch;
    alloc_pred_i    = pred;
    alloc_lpred_i   = lpred;
    alloc_ch_we_i   = chwe;
    retire_valid_i  = rv;
    retire_brdir_i  = brdir;
    flush_i         = fl;
    @(posedge clock);
    #1;
    alloc_valid_i  = 1'b0;
    retire_valid_i = 1'b0;
    retire_brdir_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [11:0] bhr, input logic [9:0] loch,
                      input logic pred, input logic lpred, input logic chwe);
    drive(1'b1, pc, bhr, loch, pred, lpred, chwe, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic retire(input logic brdir);
    drive(1'b0, 64'h0, 12'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, brdir, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 12'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_ready", alloc_ready_o,   1);
    chk("rst_count", bob_count_o,     0);
    chk("rst_valid", bob_valid_r_o,   0);
    chk("rst_under", bob_underflow_o, 0);
    chk("rst_pc",    bob_pc_r_o,      0);
    @(posedge clock); #1;
    reset_n = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    flush_i = 0; alloc_valid_i = 0; alloc_pc_i = 0; alloc_bhr_i = 0; alloc_lochist_i = 0;
    alloc_pred_i = 0; alloc_lpred_i = 0; alloc_ch_we_i = 0;
    retire_valid_i = 0; retire_brdir_i = 0;
    do_reset();

    // 1: three pushes and in-order retires
    push(64'h1000, 12'h011, 10'h001, 1'b1, 1'b1, 1'b0);
    push(64'h1004, 12'h022, 10'h002, 1'b1, 1'b1, 1'b0);
    push(64'h1008, 12'h033, 10'h003, 1'b1, 1'b1, 1'b0);
    chk("t1_count3", bob_count_o, 3);
    retire(1'b1);
    chk("t1_pc0",  bob_pc_r_o, 64'h1000);
    chk("t1_ud0",  bpd_rt_ud_o, 1);
    chk("t1_mis0", bob_mispredict_o, 0);
    retire(1'b1);
    chk("t1_pc1",  bob_pc_r_o, 64'h1004);
    retire(1'b1);
    chk("t1_pc2",  bob_pc_r_o, 64'h1008);
    chk("t1_count0", bob_count_o, 0);
    idle();
    chk("t1_ud_low", bpd_rt_ud_o, 0);
    chk("t1_pc_hold", bob_pc_r_o, 64'h1008);

    // 2: fill, refused pushes, retire-frees-slot, wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      push(64'h2000 + 64'(4 * i), 12'(i), 10'(i), 1'b1, 1'b1, 1'b0);
    chk("t2_ready_full", alloc_ready_o, 0);
    chk("t2_count16",    bob_count_o, 16);
    push(64'h9999, 12'h999, 10'h099, 1'b1, 1'b1, 1'b0);
    chk("t2_ignored",    bob_count_o, 16);
    drive(1'b1, 64'h8888, 12'h888, 10'h088, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t2_ready_back", alloc_ready_o, 1);
    chk("t2_count15",    bob_count_o, 15);
    chk("t2_pc_head",    bob_pc_r_o, 64'h2000);
    push(64'h3000, 12'h300, 10'h030, 1'b1, 1'b1, 1'b0);
    chk("t2_refull",     bob_count_o, 16);
    chk("t2_ready_off",  alloc_ready_o, 0);
    for (int i = 0; i < DEPTH; i++) retire(1'b1);
    chk("t2_last_pc",    bob_pc_r_o, 64'h3000);
    chk("t2_drained",    bob_count_o, 0);

    // 3: mispredict with same-cycle alloc
    for (int i = 0; i < 5; i++)
      push(64'h4000 + 64'(4 * i), 12'h0A0 + 12'(i), 10'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 64'h5000, 12'h500, 10'h050, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_misp",  bob_mispredict_o, 1);
    chk("t3_bhr",   bob_bhr_r_o, 12'h0A0);
    chk("t3_count", bob_count_o, 0);
    idle();
    chk("t3_misp_low", bob_mispredict_o, 0);
    chk("t3_count_idle", bob_count_o, 0);

    // 4: choice-table update
    push(64'h6000, 12'h060, 10'h006, 1'b1, 1'b0, 1'b1);
    retire(1'b1);
    chk("t4_chwe1",  bpd_ch_we_o, 1);
    chk("t4_chdir1", bpd_ch_dir_o, 1);
    push(64'h6000, 12'h060, 10'h006, 1'b1, 1'b0, 1'b1);
    retire(1'b0);
    chk("t4_chwe2",  bpd_ch_we_o, 1);
    chk("t4_chdir0", bpd_ch_dir_o, 0);
    chk("t4_misp",   bob_mispredict_o, 1);

    // 5: underflow, then flush with retire
    retire(1'b1);
    chk("t5_no_valid", bob_valid_r_o, 0);
    chk("t5_under",    bob_underflow_o, 1);
    idle();
    chk("t5_sticky",   bob_underflow_o, 1);
    for (int i = 0; i < 4; i++)
      push(64'h7000 + 64'(4 * i), 12'h070, 10'h007, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 12'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_flush_ud",  bpd_rt_ud_o, 1);
    chk("t5_flush_pc",  bob_pc_r_o, 64'h7000);
    chk("t5_flush_cnt", bob_count_o, 0);
    idle();
    chk("t5_ud_low",    bpd_rt_ud_o, 0);

    // 6: statistics, 10 retires with 3 mispredicts
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(64'h8000 + 64'(4 * i), 12'(i), 10'(i), 1'b1, 1'b1, 1'b0);
      retire((i < 3) ? 1'b0 : 1'b1);
    end
    idle();
`ifdef BPD_BOB_STATS_EN
    chk("t6_retired", stat_retired_o, 10);
    chk("t6_mispred", stat_mispred_o, 3);
`else
    chk("t6_retired", stat_retired_o, 0);
    chk("t6_mispred", stat_mispred_o, 0);
`endif
    chk("t6_under_clr", bob_underflow_o, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpd_bob.md
Name: bpd_bob

Overview:
- Branch order buffer: the retire-side counterpart of the fetch-stage tournament predictor.
- Fetch pushes one entry per predicted conditional branch. Each entry snapshots the PC, the global history (BHR), the local history, the final prediction and the local-predictor bit.
- At in-order branch resolve, the head entry is popped. The block then drives the predictor-update bus (bob_*, bpd_rt_*), the choice-table update, and the mispredict/history-restore request back to fetch.

Parameters:
- DEPTH, 16, number of entries (power of two, >=2)
- LOGDEPTH, 4, log2(DEPTH)

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high (named reset_n)
- flush_i  in  1  external pipeline flush; empties buffer
- alloc_valid_i  in  1  push request from fetch
- alloc_pc_i  in  64  branch PC
- alloc_bhr_i  in  12  BHR value used for the prediction
- alloc_lochist_i  in  10  local history used for the prediction
- alloc_pred_i  in  1  final predicted direction
- alloc_lpred_i  in  1  local-predictor direction
- alloc_ch_we_i  in  1  global^local disagreement flag
- alloc_ready_o  out  1  buffer not full (registered)
- retire_valid_i  in  1  head branch resolved this cycle
- retire_brdir_i  in  1  actual direction of head branch
- bob_pc_r_o  out  64  popped PC
- bob_bhr_r_o  out  12  popped BHR
- bob_lochist_r_o  out  10  popped local history
- bob_valid_r_o  out  1  bob_* outputs hold a valid popped entry (1-cycle pulse)
- bpd_rt_ud_o  out  1  PHT update strobe
- bpd_rt_brdir_o  out  1  actual direction for PHT update
- bpd_ch_we_o  out  1  choice-table write enable
- bpd_ch_dir_o  out  1  choice-table direction
- bob_mispredict_o  out  1  head mispredicted; fetch must restore history
- bob_count_o  out  LOGDEPTH+1  occupancy
- bob_underflow_o  out  1  sticky: retire seen while empty
- stat_retired_o  out  32  retired-branch counter (optional feature)
- stat_mispred_o  out  32  mispredict counter (optional feature)

Behaviour:
Reset (reset_n=1):
- Head and tail pointers are 0; count is 0.
- alloc_ready_o=1.
- All other outputs are 0.
- Entry storage is not reset.

Storage and pointers:
- Circular buffer of DEPTH entries.
- Head and tail pointers are LOGDEPTH+1 bits: the MSB is the wrap bit.
- Empty when head==tail. Full when the index bits are equal and the wrap bits differ.
- Pointers increment modulo 2^(LOGDEPTH+1), so the index wraps naturally.

Allocation:
- An entry is written at tail on posedge when alloc_valid_i & alloc_ready_o & !drop.
- drop = flush_i | (a mispredicting retire in the same cycle).
- An alloc_valid_i with alloc_ready_o=0 is ignored; fetch must hold it.

Ready timing:
- alloc_ready_o is registered: it is computed from next-state count, ready = (count_next != DEPTH).
- A retire in the full cycle therefore raises ready on the next cycle. A same-cycle alloc while full is still refused.

Retire:
- On retire_valid_i with the buffer non-empty, the head entry is popped and the outputs below are registered, all valid for 1 cycle (latency 1):
  - bob_pc_r_o, bob_bhr_r_o, bob_lochist_r_o = entry fields.
  - bob_valid_r_o=1, bpd_rt_ud_o=1, bpd_rt_brdir_o=retire_brdir_i.
  - bpd_ch_we_o = entry.ch_we.
  - bpd_ch_dir_o = retire_brdir_i ^ entry.lpred (1=favour global).
  - bob_mispredict_o = retire_brdir_i ^ entry.pred.
- On a mispredict, all remaining (younger, wrong-path) entries are discarded: tail:=head+1 (buffer empty after the pop).
- All strobes return to 0 in the following cycle unless a new retire occurs; the data outputs hold their last value.
- retire_valid_i while empty: no pop, no strobes, bob_underflow_o set (cleared only by reset).

Flush:
- flush_i sets head:=tail (buffer empty) and emits no strobes of its own.
- If retire_valid_i is asserted in the same cycle, the retire is processed first (its strobes are emitted next cycle), then the buffer is emptied.
- Mid-operation reset: state returns to reset values immediately; any pending strobe is lost.

Count:
- count = tail-head (LOGDEPTH+1 bits, modular).
- Simultaneous alloc and retire on a non-full, non-empty buffer leaves the count unchanged.

Optional Feature:
- Macro BPD_BOB_STATS_EN.
- Defined: stat_retired_o increments on every successful pop; stat_mispred_o increments on every pop with bob_mispredict_o. Both are 32-bit, saturating at 32'hFFFF_FFFF, reset to 0, and unaffected by flush_i.
- Undefined: both outputs are tied to 32'h0 and no counter logic is instantiated.

Test Plan:
1. Reset, then push 3 entries (PCs 0x1000/0x1004/0x1008, pred=1), retire 3 with brdir=1 -> three 1-cycle bpd_rt_ud_o pulses one cycle after each retire, bob_pc_r_o 0x1000 then 0x1004 then 0x1008, bob_mispredict_o=0, count 3→0.
2. Fill 16 entries -> alloc_ready_o=0 on the cycle after the 16th push, count=16. A 17th push is ignored. Retire 1 with a same-cycle alloc -> alloc refused, ready=1 on the next cycle, then the push is accepted and tail wraps to index 0 with the wrap bit toggled.
3. Push 5 entries, retire head with pred=1, brdir=0, plus a same-cycle alloc -> bob_mispredict_o=1 and bob_bhr_r_o equals the head snapshot. The alloc is dropped and count=0 on the next cycle.
4. Entry with lpred=0, ch_we=1, retired with brdir=1 -> bpd_ch_we_o=1, bpd_ch_dir_o=1. Same entry retired with brdir=0 -> bpd_ch_dir_o=0.
5. Retire while empty -> no strobes, bob_underflow_o=1 and sticky. flush_i together with retire of a 4-entry buffer -> one update pulse, count=0.
6. With BPD_BOB_STATS_EN defined, 10 retires including 3 mispredicts -> stat_retired_o=10, stat_mispred_o=3. With the macro undefined, both outputs stay 0.
